// File: rtl/jpeg_ac_rle_encoder_if.sv
// Coefficient-in / symbol-out stream bundle for the JPEG zero-run-length stage.
// The producer side (quantiser feed plus Huffman-side ready) uses master; the encoder uses slave.
interface jpeg_ac_rle_encoder_if #(
    parameter int unsigned COEF_W = 12
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [COEF_W-1:0] in_coef;
    logic                     out_valid;
    logic                     out_ready;
    logic [3:0]               out_run;
    logic [3:0]               out_size;
    logic [COEF_W-1:0]        out_amp;
    logic                     out_dc;
    logic                     out_eob;

    modport master (
        output in_valid, in_coef, out_ready,
        input  in_ready, out_valid, out_run, out_size, out_amp, out_dc, out_eob
    );

    modport slave (
        input  in_valid, in_coef, out_ready,
        output in_ready, out_valid, out_run, out_size, out_amp, out_dc, out_eob
    );
endinterface

// File: rtl/jpeg_ac_rle_encoder.sv
// JPEG zero-run-length symbol stage: turns a zig-zag coefficient stream (BLK_LEN per block)
// into (RUN, SIZE, AMP) symbols, with DC tagging, ZRL (15/0) and EOB (0/0) insertion.
module jpeg_ac_rle_encoder #(
    parameter int unsigned COEF_W  = 12,
    parameter int unsigned BLK_LEN = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    jpeg_ac_rle_encoder_if.slave bus
);
    localparam int unsigned      IDX_W    = $clog2(BLK_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_LEN - 1);
    localparam logic [IDX_W-1:0] RUN_MAX  = IDX_W'(16);

    typedef enum logic [1:0] {StAccept, StZrl, StEmit} state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  zrun_q;
    logic              ready_en_q;
    logic              valid_q;
    logic              dc_q;
    logic              eob_q;
    logic [3:0]        run_q;
    logic [3:0]        size_q;
    logic [COEF_W-1:0] amp_q;
    logic [3:0]        lat_size_q;
    logic [COEF_W-1:0] lat_amp_q;

    logic              slot_free;
    logic              xfer;
    logic              coef_zero;
    logic [COEF_W-1:0] coef_mag;
    logic [COEF_W-1:0] amp_mask;
    logic [COEF_W-1:0] coef_amp;
    logic [3:0]        coef_size;
    logic [IDX_W-1:0]  zrun_left;

    // Output slot can take a new symbol when empty or being drained this cycle.
    assign slot_free    = !valid_q || bus.out_ready;
    // ready_en_q keeps in_ready low while reset is asserted.
    assign bus.in_ready = ready_en_q && (state_q == StAccept) && slot_free;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign coef_zero    = (bus.in_coef == '0);
    assign zrun_left    = zrun_q - RUN_MAX;

    assign bus.out_valid = valid_q;
    assign bus.out_run   = run_q;
    assign bus.out_size  = size_q;
    assign bus.out_amp   = amp_q;
    assign bus.out_dc    = dc_q;
    assign bus.out_eob   = eob_q;

    // Magnitude category and JPEG amplitude bits of the incoming coefficient.
    always_comb begin
        coef_mag  = bus.in_coef[COEF_W-1] ? (~bus.in_coef + COEF_W'(1)) : bus.in_coef;
        coef_size = '0;
        amp_mask  = '0;
        for (int i = 0; i < COEF_W; i++) begin
            if (coef_mag[i]) coef_size = 4'(i + 1);
        end
        for (int i = 0; i < COEF_W; i++) begin
            amp_mask[i] = (i < int'(coef_size));
        end
        // Negative values use one's-complement form (coef - 1) clipped to SIZE bits.
        coef_amp = bus.in_coef[COEF_W-1] ? ((bus.in_coef - COEF_W'(1)) & amp_mask)
                                         : bus.in_coef;
    end

    // Control FSM, block index / zero-run counters and the registered output slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StAccept;
            idx_q      <= '0;
            zrun_q     <= '0;
            ready_en_q <= 1'b0;
            valid_q    <= 1'b0;
            run_q      <= '0;
            size_q     <= '0;
            amp_q      <= '0;
            dc_q       <= 1'b0;
            eob_q      <= 1'b0;
            lat_size_q <= '0;
            lat_amp_q  <= '0;
        end else begin
            ready_en_q <= 1'b1;
            // Drained slot goes empty unless a new symbol is loaded below.
            if (valid_q && bus.out_ready) valid_q <= 1'b0;
            unique case (state_q)
                StAccept: begin
                    if (xfer) begin
                        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                        if (idx_q == '0) begin
                            valid_q <= 1'b1;
                            run_q   <= '0;
                            size_q  <= coef_size;
                            amp_q   <= coef_amp;
                            dc_q    <= 1'b1;
                            eob_q   <= 1'b0;
                            zrun_q  <= '0;
                        end else if (coef_zero) begin
                            if (idx_q == LAST_IDX) begin
                                // Trailing zeros collapse into EOB; pending ZRLs dropped.
                                valid_q <= 1'b1;
                                run_q   <= '0;
                                size_q  <= '0;
                                amp_q   <= '0;
                                dc_q    <= 1'b0;
                                eob_q   <= 1'b1;
                                zrun_q  <= '0;
                            end else begin
                                zrun_q <= zrun_q + IDX_W'(1);
                            end
                        end else if (zrun_q < RUN_MAX) begin
                            valid_q <= 1'b1;
                            run_q   <= zrun_q[3:0];
                            size_q  <= coef_size;
                            amp_q   <= coef_amp;
                            dc_q    <= 1'b0;
                            eob_q   <= 1'b0;
                            zrun_q  <= '0;
                        end else begin
                            // Run too long: park the symbol and emit ZRLs first.
                            lat_size_q <= coef_size;
                            lat_amp_q  <= coef_amp;
                            valid_q    <= 1'b1;
                            run_q      <= 4'd15;
                            size_q     <= '0;
                            amp_q      <= '0;
                            dc_q       <= 1'b0;
                            eob_q      <= 1'b0;
                            zrun_q     <= zrun_left;
                            state_q    <= (zrun_left >= RUN_MAX) ? StZrl : StEmit;
                        end
                    end
                end
                StZrl: begin
                    if (slot_free) begin
                        valid_q <= 1'b1;
                        run_q   <= 4'd15;
                        size_q  <= '0;
                        amp_q   <= '0;
                        dc_q    <= 1'b0;
                        eob_q   <= 1'b0;
                        zrun_q  <= zrun_left;
                        state_q <= (zrun_left >= RUN_MAX) ? StZrl : StEmit;
                    end
                end
                StEmit: begin
                    if (slot_free) begin
                        valid_q <= 1'b1;
                        run_q   <= zrun_q[3:0];
                        size_q  <= lat_size_q;
                        amp_q   <= lat_amp_q;
                        dc_q    <= 1'b0;
                        eob_q   <= 1'b0;
                        zrun_q  <= '0;
                        state_q <= StAccept;
                    end
                end
                default: state_q <= StAccept;
            endcase
        end
    end
endmodule
